// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter using the request-to-send handshake.
// Drives the shared pads through open-collector enables (_T: 1 = release, 0 = pull low).
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 3200,
  parameter int TIMEOUT_CYC = 480000,
  parameter int FILT_LEN    = 8
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic [7:0] I_TX_DATA,
  input  logic       I_TX_REQ,
  output logic       O_TX_BUSY,
  output logic       O_TX_DONE,
  output logic       O_TX_ERR,
  output logic       O_RX_INHIBIT,
  input  logic       I_PS2_CLK,
  input  logic       I_PS2_DAT,
  output logic       O_PS2_CLK_T,
  output logic       O_PS2_DAT_T
);

  localparam int CW = $clog2(INHIBIT_CYC + FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYC - 2);
  localparam logic [CW-1:0] IDLE_LAST = CW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_XFER, S_ACK_CHK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  logic [1:0]    r_clk_sync, r_dat_sync;
  logic          r_clk_filt, r_clk_filt_d;
  logic [FW-1:0] r_filt_cnt;
  logic          w_clk_s, w_dat_s, w_fall;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_to, w_to_nxt;
  logic [7:0]    r_sh, w_sh_nxt;
  logic          r_par, w_par_nxt;
  logic [3:0]    r_n, w_n_nxt;
  logic          r_ack, w_ack_nxt;
  logic          r_clk_t, w_clk_t_nxt;
  logic          r_dat_t, w_dat_t_nxt;
  logic          w_to_exp;

  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];
  assign w_fall  = r_clk_filt_d & ~r_clk_filt;

  // Pads idle high, so synchronisers and filter reset to 1 to avoid a false fall.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_clk_sync   <= 2'b11;
      r_dat_sync   <= 2'b11;
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], I_PS2_CLK};
      r_dat_sync   <= {r_dat_sync[0], I_PS2_DAT};
      r_clk_filt_d <= r_clk_filt;
      if (w_clk_s == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_clk_filt <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_to    <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_n     <= '0;
      r_ack   <= 1'b1;
      r_clk_t <= 1'b1;
      r_dat_t <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_to    <= w_to_nxt;
      r_sh    <= w_sh_nxt;
      r_par   <= w_par_nxt;
      r_n     <= w_n_nxt;
      r_ack   <= w_ack_nxt;
      r_clk_t <= w_clk_t_nxt;
      r_dat_t <= w_dat_t_nxt;
    end
  end

  assign w_to_exp = (r_to == TO_LAST);

  // NOTE: every signal gets a hold default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = r_to;
    w_sh_nxt    = r_sh;
    w_par_nxt   = r_par;
    w_n_nxt     = r_n;
    w_ack_nxt   = r_ack;
    w_clk_t_nxt = r_clk_t;
    w_dat_t_nxt = r_dat_t;
    case (r_state)
      S_IDLE: begin
        w_clk_t_nxt = 1'b1;
        w_dat_t_nxt = 1'b1;
        if (I_TX_REQ) begin
          w_sh_nxt    = I_TX_DATA;
          w_par_nxt   = ~^I_TX_DATA;
          w_cnt_nxt   = '0;
          w_clk_t_nxt = 1'b0;
          w_state_nxt = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_dat_t_nxt = 1'b0;
          w_state_nxt = S_RTS;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RTS: begin
        w_clk_t_nxt = 1'b1;
        w_n_nxt     = '0;
        w_to_nxt    = '0;
        w_state_nxt = S_XFER;
      end
      S_XFER: begin
        w_to_nxt = r_to + 1'b1;
        if (w_to_exp) begin
          w_state_nxt = S_ERR;
        end else if (w_fall) begin
          w_n_nxt = r_n + 1'b1;
          if (r_n < 4'd8) begin
            w_dat_t_nxt = r_sh[0];
            w_sh_nxt    = {1'b0, r_sh[7:1]};
          end else if (r_n == 4'd8) begin
            w_dat_t_nxt = r_par;
          end else if (r_n == 4'd9) begin
            w_dat_t_nxt = 1'b1;
          end else begin
            w_ack_nxt   = w_dat_s;
            w_state_nxt = S_ACK_CHK;
          end
        end
      end
      S_ACK_CHK: begin
        w_to_nxt  = r_to + 1'b1;
        w_cnt_nxt = '0;
        if (w_to_exp || r_ack) w_state_nxt = S_ERR;
        else                   w_state_nxt = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        w_to_nxt = r_to + 1'b1;
        if (w_to_exp) begin
          w_state_nxt = S_ERR;
        end else if (w_clk_s && w_dat_s) begin
          if (r_cnt == IDLE_LAST) w_state_nxt = S_DONE;
          else                    w_cnt_nxt   = r_cnt + 1'b1;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_ERR) begin
      w_clk_t_nxt = 1'b1;
      w_dat_t_nxt = 1'b1;
    end
  end

  assign O_TX_BUSY    = !(r_state inside {S_IDLE, S_DONE, S_ERR});
  assign O_TX_DONE    = (r_state == S_DONE);
  assign O_TX_ERR     = (r_state == S_ERR);
  assign O_RX_INHIBIT = O_TX_BUSY;
  assign O_PS2_CLK_T  = r_clk_t;
  assign O_PS2_DAT_T  = r_dat_t;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 host transmitter bench with an open-collector pad model and a
// behavioural keyboard that clocks the frame, samples bits on rising edges and ACKs.
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int TO  = 3000;
  localparam int FL  = 8;

  logic       I_CLK = 1'b0;
  logic       I_RESET;
  logic [7:0] I_TX_DATA;
  logic       I_TX_REQ;
  logic       O_TX_BUSY, O_TX_DONE, O_TX_ERR, O_RX_INHIBIT;
  logic       O_PS2_CLK_T, O_PS2_DAT_T;
  logic       dev_clk, dev_dat;
  logic       w_pad_clk, w_pad_dat;

  assign w_pad_clk = O_PS2_CLK_T & dev_clk;
  assign w_pad_dat = O_PS2_DAT_T & dev_dat;

  always #5 I_CLK = ~I_CLK;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FILT_LEN(FL)) dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_TX_DATA(I_TX_DATA), .I_TX_REQ(I_TX_REQ),
    .O_TX_BUSY(O_TX_BUSY), .O_TX_DONE(O_TX_DONE), .O_TX_ERR(O_TX_ERR),
    .O_RX_INHIBIT(O_RX_INHIBIT), .I_PS2_CLK(w_pad_clk), .I_PS2_DAT(w_pad_dat),
    .O_PS2_CLK_T(O_PS2_CLK_T), .O_PS2_DAT_T(O_PS2_DAT_T)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int bad_busy = 0;
  int low_run = 0;
  int last_low_len = 0;
  logic [1:0] dat_hist = 2'b11;
  logic [1:0] last_dat_hist = 2'b11;
  logic prev_clk_t = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse counters and inhibit-window observer, sampled on the inactive edge.
  always @(negedge I_CLK) begin
    if (O_TX_DONE) done_cnt <= done_cnt + 1;
    if (O_TX_ERR)  err_cnt  <= err_cnt + 1;
    if ((O_TX_DONE || O_TX_ERR) && O_TX_BUSY) bad_busy <= bad_busy + 1;
    if (O_RX_INHIBIT !== O_TX_BUSY) bad_busy <= bad_busy + 1;
    if (!O_PS2_CLK_T) begin
      low_run  <= low_run + 1;
      dat_hist <= {dat_hist[0], O_PS2_DAT_T};
    end else if (!prev_clk_t) begin
      last_low_len  <= low_run;
      last_dat_hist <= dat_hist;
      low_run       <= 0;
    end
    prev_clk_t <= O_PS2_CLK_T;
  end

  // Reference: data LSB first, odd parity from a popcount, stop bit 1.
  function automatic logic [9:0] model_bits(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic device(input int half, input bit ack_en, input bit glitch, input int max_falls,
                        output logic [9:0] bits, output bit started);
    int t = 0;
    bit ack_ok = 1'b0;
    bits = '0;
    started = 1'b0;
    while (!(O_TX_BUSY && O_PS2_CLK_T) && t < 10000) begin
      @(negedge I_CLK);
      t++;
    end
    if (t >= 10000) return;
    started = 1'b1;
    repeat (40) @(negedge I_CLK);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) dev_dat = ack_ok ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (half) @(negedge I_CLK);
      if (i == max_falls && i < 11) return;
      dev_clk = 1'b1;
      if (i == 11) begin
        dev_dat = 1'b1;
        return;
      end
      bits[i-1] = w_pad_dat;
      if (i == 10) ack_ok = ack_en && (^bits[8:0]) && bits[9];
      if (glitch && i == 3) begin
        repeat (half / 2) @(negedge I_CLK);
        dev_clk = 1'b0;
        repeat (3) @(negedge I_CLK);
        dev_clk = 1'b1;
        repeat (half - half / 2 - 3) @(negedge I_CLK);
      end else begin
        repeat (half) @(negedge I_CLK);
      end
    end
  endtask

  task automatic wait_busy(input string tag);
    int t = 0;
    @(negedge I_CLK);
    while (!O_TX_BUSY && t < 20) begin
      @(negedge I_CLK);
      t++;
    end
    check({tag, "_accept"}, O_TX_BUSY, 1'b1);
  endtask

  task automatic wait_end(input string tag, input int base);
    int t = 0;
    while ((done_cnt + err_cnt) == base && t < 5000) begin
      @(negedge I_CLK);
      t++;
    end
    check({tag, "_end_seen"}, ((done_cnt + err_cnt) != base), 1'b1);
    repeat (4) @(negedge I_CLK);
  endtask

  task automatic send(input logic [7:0] d, input int half, input bit ack_en, input bit glitch,
                      input string tag);
    logic [9:0] bits;
    bit started;
    int bd = done_cnt;
    int be = err_cnt;
    I_TX_DATA = d;
    I_TX_REQ  = 1'b1;
    wait_busy(tag);
    I_TX_REQ  = 1'b0;
    device(half, ack_en, glitch, 11, bits, started);
    check({tag, "_started"}, started, 1'b1);
    check({tag, "_bits"}, bits, model_bits(d));
    wait_end(tag, bd + be);
    check({tag, "_done"}, done_cnt - bd, ack_en ? 1 : 0);
    check({tag, "_err"},  err_cnt - be,  ack_en ? 0 : 1);
  endtask

  initial begin
    logic [9:0] bits;
    bit started;
    logic [7:0] da, dc;
    int t, c, bd, be;

    I_RESET = 1'b1;
    I_TX_REQ = 1'b0;
    I_TX_DATA = 8'h00;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) @(negedge I_CLK);
    check("rst_clk_t", O_PS2_CLK_T, 1'b1);
    check("rst_dat_t", O_PS2_DAT_T, 1'b1);
    check("rst_busy", O_TX_BUSY, 1'b0);
    check("rst_done_err", {O_TX_DONE, O_TX_ERR}, 2'b00);
    I_RESET = 1'b0;
    repeat (5) @(negedge I_CLK);

    send(8'hED, 25, 1'b1, 1'b0, "ed");
    check("inh_len", last_low_len, INH);
    check("inh_dat_lead", last_dat_hist, 2'b10);
    send(8'h01, 22, 1'b1, 1'b0, "x01");
    send(8'h00, 30, 1'b1, 1'b0, "x00");
    for (int k = 0; k < 6; k++) begin
      send(8'($urandom), int'($urandom_range(20, 32)), 1'b1, 1'b0, "rnd");
      repeat (int'($urandom_range(1, 30))) @(negedge I_CLK);
    end
    send(8'($urandom), 24, 1'b1, 1'b1, "glitch");
    send(8'hA5, 24, 1'b0, 1'b0, "noack");

    // Device never clocks: error exactly TO cycles after clock release.
    be = err_cnt;
    bd = done_cnt;
    I_TX_DATA = 8'h3C;
    I_TX_REQ = 1'b1;
    wait_busy("to");
    I_TX_REQ = 1'b0;
    t = 0;
    while (!(O_PS2_CLK_T && O_TX_BUSY) && t < 1000) begin
      @(negedge I_CLK);
      t++;
    end
    check("to_release", O_PS2_CLK_T, 1'b1);
    c = 0;
    while (!O_TX_ERR && c < TO + 50) begin
      @(negedge I_CLK);
      c++;
    end
    check("to_cycles", c, TO);
    check("to_lines", {O_PS2_CLK_T, O_PS2_DAT_T}, 2'b11);
    check("to_busy", O_TX_BUSY, 1'b0);
    repeat (4) @(negedge I_CLK);
    check("to_err_cnt", err_cnt - be, 1);
    check("to_no_done", done_cnt - bd, 0);

    // Asynchronous reset right after fall 5, while the host drives data bit 4.
    I_TX_DATA = 8'hED;
    I_TX_REQ = 1'b1;
    wait_busy("rstmid");
    I_TX_REQ = 1'b0;
    device(24, 1'b1, 1'b0, 5, bits, started);
    check("rstmid_pre_dat", O_PS2_DAT_T, model_bits(8'hED) >> 4 & 10'h1);
    #2 I_RESET = 1'b1;
    #1;
    check("rstmid_lines", {O_PS2_CLK_T, O_PS2_DAT_T}, 2'b11);
    check("rstmid_busy", O_TX_BUSY, 1'b0);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) @(negedge I_CLK);
    I_RESET = 1'b0;
    repeat (20) @(negedge I_CLK);
    send(8'h5A, 26, 1'b1, 1'b0, "post_rst");

    // REQ held across DONE: data changed while busy is ignored; next frame starts at once.
    bd = done_cnt;
    be = err_cnt;
    da = 8'($urandom);
    dc = 8'($urandom);
    I_TX_DATA = da;
    I_TX_REQ = 1'b1;
    wait_busy("b2b");
    I_TX_DATA = ~da;
    device(23, 1'b1, 1'b0, 11, bits, started);
    check("b2b_bits1", bits, model_bits(da));
    t = 0;
    while (!O_TX_DONE && t < 2000) begin
      @(negedge I_CLK);
      t++;
    end
    check("b2b_done_seen", O_TX_DONE, 1'b1);
    I_TX_DATA = dc;
    @(negedge I_CLK);
    check("b2b_gap", O_TX_BUSY, 1'b0);
    @(negedge I_CLK);
    check("b2b_restart", O_TX_BUSY, 1'b1);
    I_TX_REQ = 1'b0;
    device(27, 1'b1, 1'b0, 11, bits, started);
    check("b2b_bits2", bits, model_bits(dc));
    wait_end("b2b", bd + be + 1);
    check("b2b_done", done_cnt - bd, 2);
    check("b2b_err", err_cnt - be, 0);

    check("busy_at_pulse", bad_busy, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
